// File: rtl/sseg_arbiter.sv
// ---------------------------------------------------------------------------
// sseg_arbiter
//
// Round-robin arbiter that shares one 4-digit 7-segment display between
// N_REQ requesters. When the arbiter is idle and any request is present, the
// winning requester's 16-bit value is latched onto the four display digits.
// That value is then held for HOLD_TICKS display ticks before another grant
// can be issued. Ticks are the 1-cycle overflow strobe of the display refresh
// counter, so the hold time is measured in display ticks, not clock cycles.
//
// Ports
//   clk          in   1              system clock, rising edge
//   rst          in   1              synchronous reset, active-high
//   tick         in   1              1-cycle display tick strobe
//   req          in   N_REQ          level request per requester
//   data         in   16*N_REQ       requester i value at data[16*i +: 16]
//   gnt          out  N_REQ          one-hot, 1-cycle grant pulse
//   owner        out  $clog2(N_REQ)  index of the last granted requester
//   busy         out  1              high while a granted value is held
//   digit0..3    out  4 each         display nibbles, digit0 = value[3:0]
//
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module sseg_arbiter #(
    parameter int N_REQ      = 4,
    parameter int HOLD_TICKS = 8,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic [N_REQ-1:0]         req,
    input  logic [16*N_REQ-1:0]      data,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [3:0]               digit0,
    output logic [3:0]               digit1,
    output logic [3:0]               digit2,
    output logic [3:0]               digit3
);

    localparam int IDX_W = $clog2(N_REQ);

    // A hold of zero ticks would never leave SHOW cleanly; treat it as one.
    localparam int                HOLD_EFF  = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_EFF);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [IDX_W-1:0]   r_owner;
    logic               r_busy;
    logic [15:0]        r_digits;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [IDX_W-1:0]   r_rr_ptr;

    // ---------------------------------------------------------------------
    // Combinational signals
    // ---------------------------------------------------------------------
    state_t             w_state_nxt;
    logic               w_any;
    logic [IDX_W-1:0]   w_winner;
    logic               w_grant;
    logic               w_count;
    logic               w_release;
    logic [IDX_W-1:0]   w_rr_nxt;

    // (base + offs) mod N_REQ for offs in [0, N_REQ); works for any N_REQ,
    // not only powers of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int               offs);
        int s;
        s = int'(base) + offs;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    // ---------------------------------------------------------------------
    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_any && req[wrap_add(r_rr_ptr, k)]) begin
                w_any    = 1'b1;
                w_winner = wrap_add(r_rr_ptr, k);
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 1: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge
        // values and the simulation matches the synthesized flops.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (tick && (r_hold_cnt == CNT_ONE)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM process 3: output / datapath control decode
    // Ticks are only counted in SHOW, so a tick coinciding with the grant
    // edge (still IDLE) does not shorten the hold window.
    // ---------------------------------------------------------------------
    always_comb begin
        w_grant   = (r_state == ST_IDLE) && w_any;
        w_count   = (r_state == ST_SHOW) && tick;
        w_release = w_count && (r_hold_cnt == CNT_ONE);
        w_rr_nxt  = (w_winner == LAST_IDX) ? '0 : (w_winner + IDX_ONE);
    end

    // ---------------------------------------------------------------------
    // Registered outputs and hold counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt      <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_digits   <= '0;
            r_hold_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            // Grant is a single-cycle pulse; default it low every cycle.
            r_gnt <= '0;
            if (w_grant) begin
                r_gnt      <= N_REQ'(1) << w_winner;
                r_digits   <= data[16*w_winner +: 16];
                r_owner    <= w_winner;
                r_busy     <= 1'b1;
                r_hold_cnt <= HOLD_LOAD;
                r_rr_ptr   <= w_rr_nxt;
            end else if (w_count) begin
                if (w_release) begin
                    r_busy     <= 1'b0;
                    r_hold_cnt <= '0;
                end else begin
                    r_hold_cnt <= r_hold_cnt - CNT_ONE;
                end
            end
        end
    end

    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign busy   = r_busy;
    assign digit0 = r_digits[3:0];
    assign digit1 = r_digits[7:4];
    assign digit2 = r_digits[11:8];
    assign digit3 = r_digits[15:12];

endmodule

// File: tb/tb_sseg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sseg_arbiter
//
// Directed bench for sseg_arbiter (N_REQ=4, HOLD_TICKS=8). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point, i.e. they
// show the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_sseg_arbiter;

    localparam int N_REQ = 4;
    localparam int HOLD  = 8;

    logic        clk;
    logic        rst;
    logic        tick;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;

    int n_checks;
    int n_fail;

    sseg_arbiter #(
        .N_REQ      (N_REQ),
        .HOLD_TICKS (HOLD),
        .CNT_W      (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .req    (req),
        .data   (data),
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .digit0 (digit0),
        .digit1 (digit1),
        .digit2 (digit2),
        .digit3 (digit3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_owner,
                             input logic e_busy, input logic [15:0] e_digits);
        check({tag, ".gnt"},    32'(gnt),   32'(e_gnt));
        check({tag, ".owner"},  32'(owner), 32'(e_owner));
        check({tag, ".busy"},   32'(busy),  32'(e_busy));
        check({tag, ".digits"}, 32'({digit3, digit2, digit1, digit0}), 32'(e_digits));
    endtask

    task automatic set_data(input int i, input logic [15:0] v);
        data[16*i +: 16] = v;
    endtask

    // Issues n ticks spaced gap cycles apart during SHOW. busy must stay high
    // after ticks 1..n-1 and drop right after tick n, with no grant yet.
    task automatic run_hold(input string tag, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i < n - 1) begin
                check($sformatf("%s.busy_t%0d", tag, i + 1), 32'(busy), 32'd1);
                repeat (gap - 1) step();
            end else begin
                check({tag, ".busy_end"}, 32'(busy), 32'd0);
                check({tag, ".gnt_end"},  32'(gnt),  32'd0);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        tick     = 1'b0;
        req      = '0;
        data     = '0;

        // T1: reset with random req/tick activity
        for (int i = 0; i < 2; i++) begin
            req  = 4'($urandom_range(15, 1));
            tick = 1'($urandom_range(1, 0));
            set_data(i, 16'hFFFF);
            step();
        end
        check_all("t1_reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
        req  = '0;
        tick = 1'b0;
        rst  = 1'b0;
        step();
        check_all("t1_idle", 4'b0000, 2'd0, 1'b0, 16'h0000);

        // T2: single requester 1 with BEEF
        set_data(1, 16'hBEEF);
        req = 4'b0010;
        step();
        check_all("t2_grant", 4'b0010, 2'd1, 1'b1, 16'hBEEF);
        req = '0;
        step();
        check("t2_gnt_pulse", 32'(gnt), 32'd0);
        run_hold("t2", HOLD, 2);

        // T3: all requesting, ticks every 4 cycles, order 0,1,2,3,0
        do_reset();
        set_data(0, 16'hA0A0);
        set_data(1, 16'hB1B1);
        set_data(2, 16'hC2C2);
        set_data(3, 16'hD3D3);
        req = 4'b1111;
        step();
        check_all("t3_g0", 4'b0001, 2'd0, 1'b1, 16'hA0A0);
        run_hold("t3_w0", HOLD, 4);
        step();
        check_all("t3_g1", 4'b0010, 2'd1, 1'b1, 16'hB1B1);
        run_hold("t3_w1", HOLD, 4);
        step();
        check_all("t3_g2", 4'b0100, 2'd2, 1'b1, 16'hC2C2);
        run_hold("t3_w2", HOLD, 4);
        step();
        check_all("t3_g3", 4'b1000, 2'd3, 1'b1, 16'hD3D3);
        run_hold("t3_w3", HOLD, 4);
        step();
        check_all("t3_g4", 4'b0001, 2'd0, 1'b1, 16'hA0A0);
        req = '0;
        run_hold("t3_w4", HOLD, 4);

        // T4: ticks in IDLE ignored, digits hold; tick in grant cycle not counted
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check_all("t4_idle", 4'b0000, 2'd0, 1'b0, 16'hA0A0);
        set_data(0, 16'h5A5A);
        req  = 4'b0001;
        tick = 1'b1;
        step();
        tick = 1'b0;
        req  = '0;
        check_all("t4_grant", 4'b0001, 2'd0, 1'b1, 16'h5A5A);
        run_hold("t4", HOLD, 3);

        // T5: req 0101 -> 0; req2 dropped in SHOW; next grant is 0 again
        do_reset();
        check_all("t5_reset", 4'b0000, 2'd0, 1'b0, 16'h0000);
        set_data(0, 16'h1357);
        set_data(2, 16'h2468);
        req = 4'b0101;
        step();
        check_all("t5_g0", 4'b0001, 2'd0, 1'b1, 16'h1357);
        req = 4'b0001;
        step();
        check("t5_gnt_pulse", 32'(gnt), 32'd0);
        run_hold("t5", HOLD, 2);
        step();
        check_all("t5_g1", 4'b0001, 2'd0, 1'b1, 16'h1357);
        step();
        check("t5_gnt_single", 32'(gnt), 32'd0);
        req = '0;

        // T6: reset at tick 3 of SHOW with 1234 shown; req3 waits for rst release
        do_reset();
        set_data(0, 16'h1234);
        set_data(3, 16'hCAFE);
        req = 4'b0001;
        step();
        check_all("t6_grant", 4'b0001, 2'd0, 1'b1, 16'h1234);
        req = '0;
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
        check("t6_busy_pre", 32'(busy), 32'd1);
        tick = 1'b1;
        rst  = 1'b1;
        req  = 4'b1000;
        step();
        tick = 1'b0;
        check_all("t6_rst", 4'b0000, 2'd0, 1'b0, 16'h0000);
        step();
        check_all("t6_rst_hold", 4'b0000, 2'd0, 1'b0, 16'h0000);
        rst = 1'b0;
        step();
        check_all("t6_g3", 4'b1000, 2'd3, 1'b1, 16'hCAFE);
        req = '0;
        step();
        check("t6_gnt_pulse", 32'(gnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
